// File: rtl/sprite_blitter_pkg.sv
// Shared constants and types for the sprite blitter and the game-flow datapath.
package sprite_blitter_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int COLOUR_W   = 9;
  localparam int ROM_ADDR_W = 14;

  localparam logic [COLOUR_W-1:0] TRANSPARENT_KEY = 9'h1FF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } blit_state_e;

  // A pixel is drawn when it is in fill mode, or its ROM colour differs from the key.
  function automatic logic pixel_visible(
    input logic                fill,
    input logic [COLOUR_W-1:0] data,
    input logic [COLOUR_W-1:0] key
  );
    return fill || (data != key);
  endfunction

endpackage

// File: rtl/blit_scan_counter.sv
// Row-major scan of a WxH rectangle: column/row counters plus a running ROM address.
module blit_scan_counter
  import sprite_blitter_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              enable,
  input  logic [7:0]        width,
  input  logic [6:0]        height,
  output logic [7:0]        col,
  output logic [6:0]        row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [7:0]        col_r;
  logic [6:0]        row_r;
  logic [ADDR_W-1:0] addr_r;
  logic              last_s;

  // Flag the final pixel of the rectangle so the scan stops on it.
  always_comb begin
    last_s = 1'b0;
    if ((col_r == (width - 8'd1)) && (row_r == (height - 7'd1))) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Advance column, wrap into the next row, and step the address accumulator.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_r  <= 8'd0;
      row_r  <= 7'd0;
      addr_r <= '0;
    end else if (clear) begin
      col_r  <= 8'd0;
      row_r  <= 7'd0;
      addr_r <= '0;
    end else if (enable) begin
      addr_r <= addr_r + ADDR_W'(1);
      if (col_r == (width - 8'd1)) begin
        col_r <= 8'd0;
        row_r <= row_r + 7'd1;
      end else begin
        col_r <= col_r + 8'd1;
      end
    end
  end

  assign col  = col_r;
  assign row  = row_r;
  assign addr = addr_r;
  assign last = last_s;

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: scans a rectangle, reads a sync sprite ROM (or a fill colour)
// and emits registered {x, y, colour, plot} for the VGA write stage.
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int                  X_MAX       = SCREEN_W,
  parameter int                  Y_MAX       = SCREEN_H,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = TRANSPARENT_KEY,
  parameter int                  ADDR_W      = ROM_ADDR_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [7:0]          src_x,
  input  logic [6:0]          src_y,
  input  logic [7:0]          width,
  input  logic [6:0]          height,
  input  logic                fill_mode,
  input  logic [COLOUR_W-1:0] fill_colour,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic                busy,
  output logic                done,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);

  blit_state_e         state_r;
  logic                hold_r;
  logic [7:0]          src_x_r;
  logic [6:0]          src_y_r;
  logic [7:0]          width_r;
  logic [6:0]          height_r;
  logic                fill_mode_r;
  logic [COLOUR_W-1:0] fill_colour_r;
  logic                busy_r;
  logic                done_r;

  logic                s1_valid_r;
  logic [7:0]          s1_col_r;
  logic [6:0]          s1_row_r;
  logic [7:0]          x_r;
  logic [6:0]          y_r;
  logic [COLOUR_W-1:0] colour_r;
  logic                plot_r;

  logic                clear_s;
  logic                enable_s;
  logic [7:0]          col_s;
  logic [6:0]          row_s;
  logic                last_s;
  logic [8:0]          sum_x_s;
  logic [7:0]          sum_y_s;
  logic                in_bounds_s;
  logic                plot_s;

  // Counter is cleared while loading and runs until the last address has been issued.
  always_comb begin
    clear_s  = 1'b0;
    enable_s = 1'b0;
    if (state_r == ST_LOAD) begin
      clear_s = 1'b1;
    end else if ((state_r == ST_SCAN) && !last_s) begin
      enable_s = 1'b1;
    end else begin
      clear_s  = 1'b0;
      enable_s = 1'b0;
    end
  end

  blit_scan_counter #(
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear_s),
    .enable (enable_s),
    .width  (width_r),
    .height (height_r),
    .col    (col_s),
    .row    (row_s),
    .addr   (rom_addr),
    .last   (last_s)
  );

  // Control FSM: latch request, scan, drain the two-stage pipeline, pulse done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      hold_r        <= 1'b0;
      src_x_r       <= 8'd0;
      src_y_r       <= 7'd0;
      width_r       <= 8'd0;
      height_r      <= 7'd0;
      fill_mode_r   <= 1'b0;
      fill_colour_r <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            src_x_r       <= src_x;
            src_y_r       <= src_y;
            width_r       <= width;
            height_r      <= height;
            fill_mode_r   <= fill_mode;
            fill_colour_r <= fill_colour;
            busy_r        <= 1'b1;
            hold_r        <= 1'b0;
            state_r       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // An empty rectangle skips the scan but still waits one extra clock,
          // so done lands two clocks after the accept.
          if ((width_r == 8'd0) || (height_r == 7'd0)) begin
            if (hold_r) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              hold_r <= 1'b1;
            end
          end else begin
            state_r <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (last_s) begin
            hold_r  <= 1'b0;
            state_r <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Two clocks: ROM latency plus the output register stage.
          if (hold_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            hold_r <= 1'b1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Screen coordinate of the pixel leaving stage 1, with clipping instead of wrapping.
  always_comb begin
    sum_x_s     = {1'b0, src_x_r} + {1'b0, s1_col_r};
    sum_y_s     = {1'b0, src_y_r} + {1'b0, s1_row_r};
    in_bounds_s = 1'b0;
    if ((sum_x_s < 9'(X_MAX)) && (sum_y_s < 8'(Y_MAX))) begin
      in_bounds_s = 1'b1;
    end else begin
      in_bounds_s = 1'b0;
    end
    plot_s = s1_valid_r && in_bounds_s && pixel_visible(fill_mode_r, rom_data, TRANSPARENT);
  end

  // Two-stage pixel pipeline aligned with the one-clock ROM read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_r <= 1'b0;
      s1_col_r   <= 8'd0;
      s1_row_r   <= 7'd0;
      x_r        <= 8'd0;
      y_r        <= 7'd0;
      colour_r   <= '0;
      plot_r     <= 1'b0;
    end else begin
      s1_valid_r <= (state_r == ST_SCAN);
      s1_col_r   <= col_s;
      s1_row_r   <= row_s;
      x_r        <= sum_x_s[7:0];
      y_r        <= sum_y_s[6:0];
      colour_r   <= fill_mode_r ? fill_colour_r : rom_data;
      plot_r     <= plot_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign x      = x_r;
  assign y      = y_r;
  assign colour = colour_r;
  assign plot   = plot_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: ROM model, pixel scoreboard, scenario tasks.
module tb_sprite_blitter;

  logic        CLOCK_50;
  logic        resetn;
  logic        start;
  logic [7:0]  src_x;
  logic [6:0]  src_y;
  logic [7:0]  width;
  logic [6:0]  height;
  logic        fill_mode;
  logic [8:0]  fill_colour;
  logic [13:0] rom_addr;
  logic [8:0]  rom_data;
  logic        busy;
  logic        done;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [8:0]  colour;
  logic        plot;

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [8:0] pc;
  } pix_t;

  pix_t exp_q[$];
  pix_t exp_pix;
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  int   e0_cnt = 0;
  int   plot_cnt = 0;
  int   done_cnt = 0;
  int   base_plots = 0;
  int   base_dones = 0;

  sprite_blitter dut (
    .clk         (CLOCK_50),
    .resetn      (resetn),
    .start       (start),
    .src_x       (src_x),
    .src_y       (src_y),
    .width       (width),
    .height      (height),
    .fill_mode   (fill_mode),
    .fill_colour (fill_colour),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .busy        (busy),
    .done        (done),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // One-clock synchronous ROM: colour equals address, key colour at address 5.
  always @(posedge CLOCK_50) rom_data <= (rom_addr == 14'd5) ? 9'h1FF : rom_addr[8:0];

  always @(posedge CLOCK_50) edge_cnt <= edge_cnt + 1;

  // Scoreboard: every plotted pixel must match the oldest expected pixel.
  always @(negedge CLOCK_50) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (plot === 1'b1) begin
      plot_cnt = plot_cnt + 1;
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_plot got (%0d,%0d,%h) want no plot", x, y, colour);
      end else begin
        exp_pix = exp_q.pop_front();
        if ({x, y, colour} !== exp_pix) begin
          bad = bad + 1;
          $display("FAIL pixel got (%0d,%0d,%h) want (%0d,%0d,%h)",
                   x, y, colour, exp_pix.px, exp_pix.py, exp_pix.pc);
        end
      end
    end
  end

  // Reference model: row-major scan, clip to 160x120, key colour at address 5 in ROM mode.
  task automatic push_rect(input int sx, input int sy, input int w, input int h,
                           input logic fm, input logic [8:0] fc);
    pix_t p;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int a;
        a = r * w + c;
        if ((sx + c) < 160 && (sy + r) < 120 && (fm || a != 5)) begin
          p.px = 8'(sx + c);
          p.py = 7'(sy + r);
          p.pc = fm ? fc : 9'(a);
          exp_q.push_back(p);
        end
      end
    end
  endtask

  // Present a request for one edge (e0), then scramble the inputs.
  task automatic launch(input logic [7:0] sx, input logic [6:0] sy, input logic [7:0] w,
                        input logic [6:0] h, input logic fm, input logic [8:0] fc);
    src_x = sx; src_y = sy; width = w; height = h; fill_mode = fm; fill_colour = fc;
    start = 1'b1;
    base_plots = plot_cnt;
    base_dones = done_cnt;
    @(posedge CLOCK_50); #1;
    e0_cnt = edge_cnt;
    start = 1'b0;
    src_x = 8'($urandom); src_y = 7'($urandom); width = 8'($urandom);
    height = 7'($urandom); fill_mode = ~fm; fill_colour = 9'($urandom);
  endtask

  // Edge index (relative to e0) at which done is first seen; -1 if it never comes.
  task automatic wait_done(output int k);
    k = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLOCK_50); #1;
      if (done === 1'b1) begin
        k = edge_cnt - e0_cnt;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge CLOCK_50);
    #1;
    total++;
    if ({busy, done, plot, x, y, colour, rom_addr} !== 41'd0) begin
      bad++;
      $display("FAIL reset_outputs got %h want 0", {busy, done, plot, x, y, colour, rom_addr});
    end
    resetn = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    total++;
    if ({busy, done, plot} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle got %b want 000", {busy, done, plot});
    end
  endtask

  task automatic test_rom_3x2;
    int k;
    push_rect(10, 20, 3, 2, 1'b0, 9'd0);
    launch(8'd10, 7'd20, 8'd3, 7'd2, 1'b0, 9'd0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rom_busy_after_accept got %b want 1", busy); end
    wait_done(k);
    total++;
    if (k != 9) begin bad++; $display("FAIL rom_done_edge got %0d want 9", k); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rom_busy_at_done got %b want 0", busy); end
    repeat (3) @(posedge CLOCK_50);
    #1;
    total++;
    if (plot_cnt - base_plots != 5) begin
      bad++; $display("FAIL rom_plot_count got %0d want 5", plot_cnt - base_plots);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rom_missing got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_fill;
    int k;
    push_rect(0, 0, 4, 1, 1'b1, 9'h0E0);
    launch(8'd0, 7'd0, 8'd4, 7'd1, 1'b1, 9'h0E0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    total++;
    if (plot !== 1'b0) begin bad++; $display("FAIL fill_plot_e2 got %b want 0", plot); end
    @(posedge CLOCK_50); #1;
    total++;
    if (plot !== 1'b1) begin bad++; $display("FAIL fill_plot_e3 got %b want 1", plot); end
    wait_done(k);
    total++;
    if (k != 7) begin bad++; $display("FAIL fill_done_edge got %0d want 7", k); end
    repeat (3) @(posedge CLOCK_50);
    #1;
    total++;
    if (plot_cnt - base_plots != 4 || exp_q.size() != 0) begin
      bad++; $display("FAIL fill_plot_count got %0d want 4", plot_cnt - base_plots);
    end
  endtask

  task automatic test_clip;
    int k;
    push_rect(158, 118, 4, 4, 1'b1, 9'h0AB);
    launch(8'd158, 7'd118, 8'd4, 7'd4, 1'b1, 9'h0AB);
    wait_done(k);
    total++;
    if (k != 19) begin bad++; $display("FAIL clip_done_edge got %0d want 19", k); end
    repeat (3) @(posedge CLOCK_50);
    #1;
    total++;
    if (plot_cnt - base_plots != 4) begin
      bad++; $display("FAIL clip_plot_count got %0d want 4", plot_cnt - base_plots);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL clip_missing got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_empty;
    int k;
    launch(8'd50, 7'd50, 8'd0, 7'd5, 1'b0, 9'd0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL empty_busy got %b want 1", busy); end
    wait_done(k);
    total++;
    if (k != 2) begin bad++; $display("FAIL empty_done_edge got %0d want 2", k); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL empty_busy_at_done got %b want 0", busy); end
    repeat (3) @(posedge CLOCK_50);
    #1;
    total++;
    if (plot_cnt - base_plots != 0 || done_cnt - base_dones != 1) begin
      bad++;
      $display("FAIL empty_counts got plots=%0d dones=%0d want plots=0 dones=1",
               plot_cnt - base_plots, done_cnt - base_dones);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    push_rect(20, 30, 4, 4, 1'b0, 9'd0);
    launch(8'd20, 7'd30, 8'd4, 7'd4, 1'b0, 9'd0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    wait_done(k);
    total++;
    if (k != 19) begin bad++; $display("FAIL repulse_done_edge got %0d want 19", k); end
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL start_on_done got busy=%b want 0", busy); end
    repeat (4) @(posedge CLOCK_50);
    #1;
    total++;
    if (plot_cnt - base_plots != 15 || exp_q.size() != 0) begin
      bad++; $display("FAIL repulse_plot_count got %0d want 15", plot_cnt - base_plots);
    end
    total++;
    if (done_cnt - base_dones != 1) begin
      bad++; $display("FAIL repulse_done_count got %0d want 1", done_cnt - base_dones);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    push_rect(40, 40, 4, 1, 1'b1, 9'h155);
    launch(8'd40, 7'd40, 8'd4, 7'd4, 1'b1, 9'h155);
    repeat (6) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    #1;
    resetn = 1'b0;
    #1;
    total++;
    if ({busy, done, plot, x, y, colour, rom_addr} !== 41'd0) begin
      bad++;
      $display("FAIL midreset_outputs got %h want 0", {busy, done, plot, x, y, colour, rom_addr});
    end
    total++;
    if (plot_cnt - base_plots != 4 || exp_q.size() != 0) begin
      bad++; $display("FAIL midreset_plots got %0d want 4", plot_cnt - base_plots);
    end
    repeat (3) @(posedge CLOCK_50);
    #1;
    resetn = 1'b1;
    repeat (25) @(posedge CLOCK_50);
    #1;
    total++;
    if (done_cnt - base_dones != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_abandon got dones=%0d busy=%b want 0 0", done_cnt - base_dones, busy);
    end
    push_rect(5, 6, 2, 1, 1'b1, 9'h0F0);
    launch(8'd5, 7'd6, 8'd2, 7'd1, 1'b1, 9'h0F0);
    wait_done(k);
    total++;
    if (k != 5) begin bad++; $display("FAIL after_reset_done_edge got %0d want 5", k); end
    repeat (3) @(posedge CLOCK_50);
    #1;
    total++;
    if (plot_cnt - base_plots != 2 || exp_q.size() != 0) begin
      bad++; $display("FAIL after_reset_plots got %0d want 2", plot_cnt - base_plots);
    end
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    src_x = 8'd0;
    src_y = 7'd0;
    width = 8'd0;
    height = 7'd0;
    fill_mode = 1'b0;
    fill_colour = 9'd0;
    test_reset();
    test_rom_3x2();
    test_fill();
    test_clip();
    test_empty();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
